// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Arbiter FSM states, cache port identifiers and the default timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int TIMEOUT_CNT_W   = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I-cache, D-cache, arbiter and the block data memory.
// The arbiter uses the slave view; the surrounding environment uses the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) ();

  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_writedata;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport slave (
    input  i_read, i_write, i_address, i_writedata,
    output i_readdata, i_busywait,
    input  d_read, d_write, d_address, d_writedata,
    output d_readdata, d_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport master (
    output i_read, i_write, i_address, i_writedata,
    input  i_readdata, i_busywait,
    output d_read, d_write, d_address, d_writedata,
    input  d_readdata, d_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );

endinterface

// File: rtl/rr_picker2.sv
// Two-way round-robin pick: on a tie the port that was not granted last wins.
module rr_picker2
  import mem_arb_pkg::*;
(
  input  logic  i_reqI,
  input  logic  i_reqD,
  input  port_t i_lastGrant,
  output port_t o_pick,
  output logic  o_valid
);

  always_comb begin
    o_valid = i_reqI | i_reqD;
    o_pick  = PORT_I;
    if (i_reqI && i_reqD) begin
      if (i_lastGrant == PORT_I) o_pick = PORT_D;
      else                       o_pick = PORT_I;
    end else if (i_reqD) begin
      o_pick = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block data memory between the I-cache and D-cache, one transfer at a time,
// round-robin on contention, with a sticky timeout flag when the memory never completes.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic         timeout_err
);

  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_CNT = TIMEOUT_CNT_W'(TIMEOUT);

  arb_state_t               r_state;
  port_t                    r_winner;
  port_t                    r_lastGrant;
  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_wdata;
  logic                     r_isWrite;
  logic [TIMEOUT_CNT_W-1:0] r_count;
  logic                     r_timeoutErr;
  logic [DATA_W-1:0]        r_iRdata;
  logic [DATA_W-1:0]        r_dRdata;

  logic                     w_iReq;
  logic                     w_dReq;
  port_t                    w_pick;
  logic                     w_pickValid;
  logic                     w_active;
  logic                     w_done;
  logic [TIMEOUT_CNT_W-1:0] w_countNext;

  assign w_iReq      = bus.i_read | bus.i_write;
  assign w_dReq      = bus.d_read | bus.d_write;
  assign w_active    = (r_state == GRANT) || (r_state == WAIT);
  assign w_done      = (r_state == WAIT) && !bus.mem_busywait;
  assign w_countNext = (r_count == '1) ? r_count : r_count + 1'b1;

  rr_picker2 u_picker (
    .i_reqI      (w_iReq),
    .i_reqD      (w_dReq),
    .i_lastGrant (r_lastGrant),
    .o_pick      (w_pick),
    .o_valid     (w_pickValid)
  );

  // The transfer is latched at grant so a withdrawn request still completes unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_winner     <= PORT_I;
      r_lastGrant  <= PORT_I;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_isWrite    <= 1'b0;
      r_count      <= '0;
      r_timeoutErr <= 1'b0;
      r_iRdata     <= '0;
      r_dRdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickValid) begin
            r_winner <= w_pick;
            r_state  <= GRANT;
            if (w_pick == PORT_D) begin
              r_addr    <= bus.d_address;
              r_wdata   <= bus.d_writedata;
              r_isWrite <= bus.d_write;
            end else begin
              r_addr    <= bus.i_address;
              r_wdata   <= bus.i_writedata;
              r_isWrite <= bus.i_write;
            end
          end
        end
        GRANT: begin
          r_count <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.mem_busywait) begin
            r_count <= w_countNext;
            if (w_countNext >= TIMEOUT_CNT) r_timeoutErr <= 1'b1;
          end else begin
            r_lastGrant <= r_winner;
            r_state     <= IDLE;
            if (!r_isWrite) begin
              if (r_winner == PORT_D) r_dRdata <= bus.mem_readdata;
              else                    r_iRdata <= bus.mem_readdata;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes fall in the completion cycle and while reset is asserted, without waiting for an edge.
  assign bus.mem_read      = w_active && !r_isWrite && !w_done && !reset;
  assign bus.mem_write     = w_active &&  r_isWrite && !w_done && !reset;
  assign bus.mem_address   = w_active ? r_addr  : '0;
  assign bus.mem_writedata = w_active ? r_wdata : '0;

  assign bus.i_busywait = w_iReq && !(w_done && (r_winner == PORT_I));
  assign bus.d_busywait = w_dReq && !(w_done && (r_winner == PORT_D));

  // The winner sees fresh memory data in its completion cycle; afterwards the held copy.
  assign bus.i_readdata = (w_done && !r_isWrite && (r_winner == PORT_I)) ? bus.mem_readdata : r_iRdata;
  assign bus.d_readdata = (w_done && !r_isWrite && (r_winner == PORT_D)) ? bus.mem_readdata : r_dRdata;

  assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory with programmable latency,
// cache-side drivers, and a scoreboard of expected memory transfers in grant order.
module tb_mem_arbiter;

  typedef struct packed {
    logic        isWrite;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } req_t;

  logic clock;
  logic reset;
  logic timeoutErr;

  int total = 0;
  int bad   = 0;

  xfer_t expQ[$];
  req_t  iReqQ[$];
  req_t  dReqQ[$];
  int    iDoneCyc[$];
  int    dDoneCyc[$];
  logic [31:0] iRdata[$];
  logic [31:0] dRdata[$];

  int          memLatency = 1;
  int          memCnt = 0;
  logic [31:0] memArray [64];
  xfer_t       monExp;

  mem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(6), .DATA_W(32), .TIMEOUT(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .timeout_err (timeoutErr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] pattern(input logic [5:0] a);
    if (a == 6'h05) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {26'd0, a};
  endfunction

  // Behavioural memory: busy for memLatency cycles after the grant cycle, writes land at grant.
  assign bus.mem_busywait = (memCnt != 0) && (memCnt <= memLatency);
  assign bus.mem_readdata = pattern(bus.mem_address);

  always @(posedge clock) begin
    if (bus.mem_read || bus.mem_write) begin
      if (memCnt == 0 && bus.mem_write) memArray[bus.mem_address] = bus.mem_writedata;
      memCnt <= memCnt + 1;
    end else begin
      memCnt <= 0;
    end
  end

  // Every grant cycle is matched against the next expected transfer.
  always begin
    @(negedge clock);
    #2;
    if ((bus.mem_read || bus.mem_write) && memCnt == 0) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL grant_unexpected got addr=%0h wr=%b exp none", bus.mem_address, bus.mem_write);
      end else begin
        monExp = expQ.pop_front();
        if ({bus.mem_write, bus.mem_read, bus.mem_address} !== {monExp.isWrite, ~monExp.isWrite, monExp.addr} ||
            (monExp.isWrite && bus.mem_writedata !== monExp.wdata)) begin
          bad++;
          $display("[TB] FAIL grant_xfer got wr=%b rd=%b addr=%0h wd=%0h exp wr=%b addr=%0h wd=%0h",
                   bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_writedata,
                   monExp.isWrite, monExp.addr, monExp.wdata);
        end
      end
    end
  end

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Drives both cache ports from their request queues, advancing a port once it sees busywait low.
  task automatic runPorts(input int budget, output bit ok);
    int c = 0;
    ok = 1'b0;
    iDoneCyc.delete(); dDoneCyc.delete(); iRdata.delete(); dRdata.delete();
    while (c < budget) begin
      @(negedge clock);
      if (iReqQ.size() != 0) begin
        bus.i_read = iReqQ[0].rd; bus.i_write = iReqQ[0].wr;
        bus.i_address = iReqQ[0].addr; bus.i_writedata = iReqQ[0].wdata;
      end else begin
        bus.i_read = 1'b0; bus.i_write = 1'b0;
      end
      if (dReqQ.size() != 0) begin
        bus.d_read = dReqQ[0].rd; bus.d_write = dReqQ[0].wr;
        bus.d_address = dReqQ[0].addr; bus.d_writedata = dReqQ[0].wdata;
      end else begin
        bus.d_read = 1'b0; bus.d_write = 1'b0;
      end
      if (iReqQ.size() == 0 && dReqQ.size() == 0) begin
        ok = 1'b1;
        break;
      end
      #1;
      if (iReqQ.size() != 0 && !bus.i_busywait) begin
        iDoneCyc.push_back(c); iRdata.push_back(bus.i_readdata); void'(iReqQ.pop_front());
      end
      if (dReqQ.size() != 0 && !bus.d_busywait) begin
        dDoneCyc.push_back(c); dRdata.push_back(bus.d_readdata); void'(dReqQ.pop_front());
      end
      c++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.d_read = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if ({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata,
         bus.i_readdata, bus.d_readdata, timeoutErr} !== 105'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got rd=%b wr=%b addr=%0h wd=%0h ird=%0h drd=%0h to=%b exp all zero",
               bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata,
               bus.i_readdata, bus.d_readdata, timeoutErr);
    end
    total++;
    if ({bus.i_busywait, bus.d_busywait} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL reset_busywait got %b exp 01", {bus.i_busywait, bus.d_busywait});
    end
    bus.d_read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    bit expRead;
    bit expBusy;
    memLatency = 5;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      if (c == 0) begin
        bus.d_read = 1'b1; bus.d_address = 6'h05;
        expQ.push_back('{1'b0, 6'h05, 32'h0});
      end
      if (c == 8) bus.d_read = 1'b0;
      #1;
      expRead = (c >= 1) && (c <= 6);
      expBusy = (c <= 6);
      total++;
      if ({bus.mem_read, bus.d_busywait, bus.i_busywait} !== {expRead, expBusy, 1'b0}) begin
        bad++;
        $display("[TB] FAIL single_read_c%0d got rd/dbw/ibw=%b exp %b", c,
                 {bus.mem_read, bus.d_busywait, bus.i_busywait}, {expRead, expBusy, 1'b0});
      end
      if (c >= 7) begin
        total++;
        if (bus.d_readdata !== 32'hDEADBEEF) begin
          bad++;
          $display("[TB] FAIL single_read_data_c%0d got %0h exp deadbeef", c, bus.d_readdata);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    pulseReset();
    memLatency = 2;
    iReqQ.push_back('{1'b1, 1'b0, 6'h01, 32'h0});
    dReqQ.push_back('{1'b0, 1'b1, 6'h02, 32'h12345678});
    expQ.push_back('{1'b1, 6'h02, 32'h12345678});
    expQ.push_back('{1'b0, 6'h01, 32'h0});
    runPorts(40, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL simul_budget got timeout exp completion"); end
    total++;
    if (dDoneCyc.size() != 1 || dDoneCyc[0] != 4) begin
      bad++; $display("[TB] FAIL simul_d_done got %p exp 4", dDoneCyc);
    end
    total++;
    if (iDoneCyc.size() != 1 || iDoneCyc[0] != 9 || iRdata[0] !== pattern(6'h01)) begin
      bad++; $display("[TB] FAIL simul_i_done got cyc=%p data=%p exp 9 %0h", iDoneCyc, iRdata, pattern(6'h01));
    end
    total++;
    if (memArray[2] !== 32'h12345678) begin
      bad++; $display("[TB] FAIL simul_mem_write got %0h exp 12345678", memArray[2]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    memLatency = 1;
    dReqQ.push_back('{1'b1, 1'b0, 6'h10, 32'h0});
    dReqQ.push_back('{1'b1, 1'b0, 6'h11, 32'h0});
    iReqQ.push_back('{1'b1, 1'b0, 6'h20, 32'h0});
    iReqQ.push_back('{1'b1, 1'b0, 6'h21, 32'h0});
    expQ.push_back('{1'b0, 6'h10, 32'h0});
    expQ.push_back('{1'b0, 6'h20, 32'h0});
    expQ.push_back('{1'b0, 6'h11, 32'h0});
    expQ.push_back('{1'b0, 6'h21, 32'h0});
    runPorts(60, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL b2b_budget got timeout exp completion"); end
    total++;
    if (dDoneCyc.size() != 2 || dDoneCyc[0] != 3 || dDoneCyc[1] != 11) begin
      bad++; $display("[TB] FAIL b2b_d_cycles got %p exp 3 11", dDoneCyc);
    end
    total++;
    if (iDoneCyc.size() != 2 || iDoneCyc[0] != 7 || iDoneCyc[1] != 15) begin
      bad++; $display("[TB] FAIL b2b_i_cycles got %p exp 7 15", iDoneCyc);
    end
    total++;
    if (dRdata.size() != 2 || dRdata[0] !== pattern(6'h10) || dRdata[1] !== pattern(6'h11) ||
        iRdata.size() != 2 || iRdata[0] !== pattern(6'h20) || iRdata[1] !== pattern(6'h21)) begin
      bad++; $display("[TB] FAIL b2b_data got d=%p i=%p", dRdata, iRdata);
    end
  endtask

  task automatic test_read_write_same_port();
    bit ok;
    memLatency = 1;
    iReqQ.push_back('{1'b1, 1'b1, 6'h03, 32'h0BADF00D});
    expQ.push_back('{1'b1, 6'h03, 32'h0BADF00D});
    runPorts(20, ok);
    total++;
    if (!ok || iDoneCyc.size() != 1 || iDoneCyc[0] != 3) begin
      bad++; $display("[TB] FAIL rw_done got ok=%b cyc=%p exp 3", ok, iDoneCyc);
    end
    total++;
    if (memArray[3] !== 32'h0BADF00D) begin
      bad++; $display("[TB] FAIL rw_mem_write got %0h exp badf00d", memArray[3]);
    end
  endtask

  task automatic test_timeout();
    memLatency = 1000;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clock);
      if (c == 0) begin
        bus.d_read = 1'b1; bus.d_address = 6'h06;
        expQ.push_back('{1'b0, 6'h06, 32'h0});
      end
      if (c == 13) memLatency = 0;
      if (c == 14) bus.d_read = 1'b0;
      #1;
      if (c == 11) begin
        total++;
        if (timeoutErr !== 1'b0) begin bad++; $display("[TB] FAIL timeout_early got %b exp 0", timeoutErr); end
      end
      if (c == 12) begin
        total++;
        if ({timeoutErr, bus.d_busywait} !== 2'b11) begin
          bad++; $display("[TB] FAIL timeout_set got err/bw=%b exp 11", {timeoutErr, bus.d_busywait});
        end
      end
      if (c == 13) begin
        total++;
        if ({bus.d_busywait, bus.d_readdata} !== {1'b0, pattern(6'h06)}) begin
          bad++; $display("[TB] FAIL timeout_complete got bw=%b data=%0h exp 0 %0h",
                          bus.d_busywait, bus.d_readdata, pattern(6'h06));
        end
      end
      if (c == 16) begin
        total++;
        if (timeoutErr !== 1'b1) begin bad++; $display("[TB] FAIL timeout_sticky got %b exp 1", timeoutErr); end
      end
    end
    memLatency = 1;
  endtask

  task automatic test_reset_during_wait();
    int doneCyc = -1;
    logic [31:0] got = '0;
    memLatency = 5;
    for (int c = 0; c <= 25 && doneCyc < 0; c++) begin
      @(negedge clock);
      if (c == 0) begin
        bus.i_read = 1'b1; bus.i_write = 1'b0; bus.i_address = 6'h07;
        expQ.push_back('{1'b0, 6'h07, 32'h0});
        expQ.push_back('{1'b0, 6'h07, 32'h0});
      end
      if (c == 4) begin
        #1;
        total++;
        if (bus.mem_read !== 1'b1) begin bad++; $display("[TB] FAIL rstwait_pre got rd=%b exp 1", bus.mem_read); end
        reset = 1'b1;
      end
      if (c == 5) reset = 1'b0;
      #1;
      if (c == 4) begin
        total++;
        if (bus.mem_read !== 1'b0) begin bad++; $display("[TB] FAIL rstwait_drop got rd=%b exp 0", bus.mem_read); end
      end
      if (c == 5) begin
        total++;
        if ({bus.mem_read, timeoutErr, bus.i_busywait} !== 3'b001) begin
          bad++; $display("[TB] FAIL rstwait_idle got rd/to/ibw=%b exp 001", {bus.mem_read, timeoutErr, bus.i_busywait});
        end
      end
      if (c > 5 && !bus.i_busywait) begin
        doneCyc = c;
        got = bus.i_readdata;
      end
    end
    @(negedge clock);
    bus.i_read = 1'b0;
    total++;
    if (doneCyc != 12 || got !== pattern(6'h07)) begin
      bad++; $display("[TB] FAIL rstwait_regrant got cyc=%0d data=%0h exp 12 %0h", doneCyc, got, pattern(6'h07));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.i_read = 1'b0; bus.i_write = 1'b0; bus.i_address = '0; bus.i_writedata = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_writedata = '0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_read_write_same_port();
    test_timeout();
    test_reset_during_wait();
    repeat (3) @(negedge clock);
    total++;
    if (expQ.size() != 0) begin
      bad++; $display("[TB] FAIL grants_missing got %0d pending exp 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
